// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle control FSM sequencing ALU, MUL/DIV, memory, clear and halt instructions
module controle_multiciclo #(
  parameter int MULDIV_LAT  = 4,
  parameter int CLEAR_DEPTH = 16,
  parameter int ADDR_W      = 4,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        OpCode,
  input  logic              mem_ready,
  output logic              MemtoReg,
  output logic              MemEn,
  output logic              MemOp,
  output logic              FonteEscrita,
  output logic              RegEsc,
  output logic [3:0]        ALUCode,
  output logic              Clear,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              Stop,
  output logic              err,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, ALU, MULDIV, MEM, CLR, HALT} state_t;
  state_t      state;
  logic [2:0]  op;
  logic [15:0] cnt;
  logic        md_last, mem_last, clr_last, rd, wr, clr;
  assign md_last  = cnt == 16'(MULDIV_LAT - 1);
  assign mem_last = cnt == 16'(MEM_TIMEOUT - 1);
  assign clr_last = cnt == 16'(CLEAR_DEPTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          op    <= OpCode;
          cnt   <= '0;
          state <= OpCode[2] ? (OpCode[1] ? MEM : (OpCode[0] ? HALT : CLR))
                             : (OpCode[1] ? MULDIV : ALU);
        end
        ALU: state <= IDLE;
        MULDIV: if (md_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else cnt <= cnt + 16'd1;
        // a response in the last allowed cycle still counts as success
        MEM: if (mem_ready) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (mem_last) begin
          state <= HALT;
          err   <= 1'b1;
          cnt   <= '0;
        end else cnt <= cnt + 16'd1;
        CLR: if (clr_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else cnt <= cnt + 16'd1;
        default: ;
      endcase
    end
  assign rd           = state == MEM && !op[0];
  assign wr           = state == MEM && op[0];
  assign clr          = state == CLR;
  assign instr_ready  = state == IDLE;
  assign busy         = state != IDLE && state != HALT;
  assign Stop         = state == HALT;
  assign ALUCode      = (state == ALU || state == MULDIV)
                        ? (op[1] ? (op[0] ? 4'b0010 : 4'b0001) : (op[0] ? 4'b0100 : 4'b1000))
                        : 4'b0000;
  assign RegEsc       = state == ALU || (state == MULDIV && md_last) || (rd && mem_ready);
  assign MemEn        = rd || wr || clr;
  assign MemOp        = wr || clr;
  assign MemtoReg     = rd;
  assign FonteEscrita = rd;
  assign Clear        = clr;
  assign clear_addr   = clr ? ADDR_W'(cnt) : '0;
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: table-driven per-cycle vectors checked through an expected-output scoreboard
module tb_controle_multiciclo;
  logic       clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0;
  logic [2:0] OpCode = 3'd0;
  logic       instr_ready, MemtoReg, MemEn, MemOp, FonteEscrita, RegEsc, Clear, Stop, err, busy;
  logic [3:0] ALUCode, clear_addr;
  int checks = 0, failures = 0;

  controle_multiciclo dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .OpCode(OpCode), .mem_ready(mem_ready), .MemtoReg(MemtoReg), .MemEn(MemEn),
    .MemOp(MemOp), .FonteEscrita(FonteEscrita), .RegEsc(RegEsc), .ALUCode(ALUCode),
    .Clear(Clear), .clear_addr(clear_addr), .Stop(Stop), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, v, mr;
    logic [2:0]  op;
    logic [17:0] e;
    string       tag;
  } vec_t;
  typedef struct {
    logic [17:0] e;
    string       tag;
  } sb_t;
  vec_t vecs[$];
  sb_t  sbq[$];

  // order: ready busy alu[4] regesc memen memop m2r fe clear addr[4] stop err
  function automatic logic [17:0] ex(logic ir, logic b, logic [3:0] a, logic re, logic me,
                                     logic mo, logic m2r, logic fe, logic c, logic [3:0] ca,
                                     logic st, logic er);
    return {ir, b, a, re, me, mo, m2r, fe, c, ca, st, er};
  endfunction
  function automatic logic [17:0] e_idle();             return ex(1,0,4'b0,0,0,0,0,0,0,4'd0,0,0); endfunction
  function automatic logic [17:0] e_alu(logic [3:0] a, logic re); return ex(0,1,a,re,0,0,0,0,0,4'd0,0,0); endfunction
  function automatic logic [17:0] e_rd(logic re);       return ex(0,1,4'b0,re,1,0,1,1,0,4'd0,0,0); endfunction
  function automatic logic [17:0] e_wr();               return ex(0,1,4'b0,0,1,1,0,0,0,4'd0,0,0); endfunction
  function automatic logic [17:0] e_clr(logic [3:0] ca); return ex(0,1,4'b0,0,1,1,0,0,1,ca,0,0); endfunction
  function automatic logic [17:0] e_halt(logic er);     return ex(0,0,4'b0,0,0,0,0,0,0,4'd0,1,er); endfunction

  task automatic add(logic r, logic v, logic [2:0] op, logic mr, logic [17:0] e, string tag);
    vec_t x;
    x.r = r; x.v = v; x.op = op; x.mr = mr; x.e = e; x.tag = tag;
    vecs.push_back(x);
  endtask

  always @(negedge clk)
    if (sbq.size() > 0) begin
      sb_t s;
      logic [17:0] got;
      s = sbq.pop_front();
      got = {instr_ready, busy, ALUCode, RegEsc, MemEn, MemOp, MemtoReg, FonteEscrita,
             Clear, clear_addr, Stop, err};
      checks++;
      if (got !== s.e) begin
        failures++;
        $display("FAIL %s got=%b exp=%b", s.tag, got, s.e);
      end
    end

  initial begin
    add(1,0,3'd0,0,e_idle(),"reset");
    add(0,1,3'd0,0,e_idle(),"add_accept");
    add(0,0,3'd0,0,e_alu(4'b1000,1),"add_exec");
    add(0,0,3'd0,0,e_idle(),"add_done");
    add(0,1,3'd3,0,e_idle(),"mul_accept");
    for (int i = 0; i < 4; i++) add(0,0,3'd0,0,e_alu(4'b0010, i == 3),"mul_exec");
    add(0,1,3'd2,0,e_idle(),"div_accept_b2b");
    for (int i = 0; i < 4; i++) add(0,0,3'd0,0,e_alu(4'b0001, i == 3),"div_exec");
    add(0,1,3'd6,0,e_idle(),"read_accept");
    add(0,0,3'd0,0,e_rd(0),"read_wait1");
    add(0,0,3'd0,0,e_rd(0),"read_wait2");
    add(0,0,3'd0,1,e_rd(1),"read_done");
    add(0,1,3'd7,1,e_idle(),"write_accept_mr_ignored");
    add(0,0,3'd0,1,e_wr(),"write_single");
    add(0,1,3'd1,0,e_idle(),"sub_accept");
    add(0,0,3'd0,0,e_alu(4'b0100,1),"sub_exec");
    add(0,1,3'd4,0,e_idle(),"clear_accept");
    for (int i = 0; i < 16; i++) add(0,0,3'd0,0,e_clr(4'(i)),"clear_sweep");
    add(0,1,3'd4,0,e_idle(),"clear2_accept");
    for (int i = 0; i < 8; i++) add(0,0,3'd0,0,e_clr(4'(i)),"clear2_sweep");
    add(1,0,3'd0,0,e_idle(),"clear_abort_rst");
    add(0,1,3'd0,0,e_idle(),"post_rst_add_accept");
    add(0,0,3'd0,0,e_alu(4'b1000,1),"post_rst_add_exec");
    add(0,1,3'd7,0,e_idle(),"write_late_accept");
    for (int i = 0; i < 8; i++) add(0,0,3'd0,i == 7,e_wr(),"write_late_ready");
    add(0,1,3'd7,0,e_idle(),"write_to_accept");
    for (int i = 0; i < 8; i++) add(0,0,3'd0,0,e_wr(),"write_to_wait");
    for (int i = 0; i < 4; i++) add(0,1,3'd0,1,e_halt(1),"timeout_halt");
    add(1,0,3'd0,0,e_idle(),"timeout_rst");
    add(0,1,3'd5,0,e_idle(),"halt_accept");
    for (int i = 0; i < 20; i++) add(0,1,3'd0,0,e_halt(0),"halt_sticky");
    add(1,1,3'd0,0,e_idle(),"halt_rst");
    add(0,0,3'd0,0,e_idle(),"final_idle");
    foreach (vecs[i]) begin
      sb_t s;
      @(posedge clk);
      #1;
      rst = vecs[i].r; instr_valid = vecs[i].v; OpCode = vecs[i].op; mem_ready = vecs[i].mr;
      s.e = vecs[i].e; s.tag = vecs[i].tag;
      sbq.push_back(s);
    end
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multi-cycle control unit for the 3-bit-opcode datapath. Replaces single-cycle opcode decoding with an FSM that sequences each instruction.
- Accepts one instruction per valid/ready handshake. Holds datapath control lines for the full duration of multi-cycle ALU ops, memory handshakes and memory clear sweeps. Latches the halt condition until reset.
- Sits between the instruction source and the ALU, register file and data memory.

Parameters:
- MULDIV_LAT, 4: cycles a MUL/DIV occupies, >=1.
- CLEAR_DEPTH, 16: memory words swept by CLEAR, >=1.
- ADDR_W, 4: clear address width; CLEAR_DEPTH <= 2**ADDR_W.
- MEM_TIMEOUT, 8: max cycles to wait for mem_ready, >=1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- instr_valid  in  1  OpCode is valid
- instr_ready  out  1  unit can accept an instruction
- OpCode  in  3  instruction opcode
- mem_ready  in  1  data memory completes current access
- MemtoReg  out  1  write-back source = memory
- MemEn  out  1  memory access enable
- MemOp  out  1  0 = read, 1 = write
- FonteEscrita  out  1  register-write source select
- RegEsc  out  1  register-file write strobe
- ALUCode  out  4  one-hot ALU operation
- Clear  out  1  clear sweep active
- clear_addr  out  ADDR_W  address being cleared
- Stop  out  1  processor halted (sticky)
- err  out  1  memory timeout occurred (sticky)
- busy  out  1  instruction in progress

Behaviour:
- Reset (async, any state): state=IDLE, opcode register=0, counters=0, all outputs 0 except instr_ready=1.
- Opcode map:
  - 000 ADD: ALUCode 1000
  - 001 SUB: ALUCode 0100
  - 010 DIV: ALUCode 0001
  - 011 MUL: ALUCode 0010
  - 100 CLEAR
  - 101 HALT
  - 110 READ
  - 111 WRITE
- Outputs not listed for a state are 0. ALUCode is 0000 outside ALU states.
- Outputs are decoded from the registered state and the latched opcode only; no combinational path from OpCode to outputs.
- States: IDLE, ALU, MULDIV, MEM, CLR, HALT.
- IDLE:
  - instr_ready=1, busy=0.
  - On the edge where instr_valid&&instr_ready: latch OpCode, then go to ALU (000/001), MULDIV (010/011), CLR (100), HALT (101) or MEM (110/111).
  - The instruction's control outputs appear in the cycle after acceptance.
- In all non-IDLE states: instr_ready=0, busy=1 (HALT: busy=0).
- ALU: one cycle with ALUCode and RegEsc=1, then IDLE.
- MULDIV:
  - Lasts exactly MULDIV_LAT cycles with ALUCode held.
  - RegEsc=1 only in the last cycle, then IDLE.
  - MULDIV_LAT=1 behaves like ALU.
- MEM read (110): MemEn=1, MemOp=0, MemtoReg=1, FonteEscrita=1, held until mem_ready.
- MEM write (111): MemEn=1, MemOp=1, held until mem_ready.
- MEM completion and timeout:
  - mem_ready is sampled each cycle in MEM. The cycle it is 1 is the final cycle. Read asserts RegEsc=1 in that cycle only. Next state IDLE.
  - A wait counter starts at 0 on entry and increments each MEM cycle without mem_ready.
  - If MEM_TIMEOUT cycles elapse with no mem_ready: go to HALT and set err=1.
  - mem_ready in cycle MEM_TIMEOUT is still a success.
  - mem_ready outside MEM is ignored.
- CLR:
  - Exactly CLEAR_DEPTH cycles with Clear=1, MemEn=1, MemOp=1.
  - clear_addr=0 in the first cycle, +1 per cycle, CLEAR_DEPTH-1 in the last cycle, then IDLE.
  - clear_addr returns to 0 outside CLR.
  - mem_ready is not required; clear writes are posted.
- HALT: Stop=1, instr_ready=0. Terminal until rst. instr_valid is ignored.
- Back-to-back: an instruction may be accepted in the IDLE cycle immediately following an instruction's final cycle. No instruction is ever accepted while busy.
- Reset mid-operation (MULDIV/MEM/CLR/HALT): immediate return to IDLE. Counters, Stop and err are cleared; the partial operation is abandoned.
- Outputs never glitch between states. RegEsc is never asserted in the same cycle as MemOp=1.

Test Plan:
- Reset then ADD accepted at cycle 0 -> cycle 1: ALUCode=1000, RegEsc=1. Cycle 2: instr_ready=1, all controls 0.
- MUL with MULDIV_LAT=4, accepted at cycle 0 -> ALUCode=0010 in cycles 1-4, RegEsc=1 only in cycle 4, instr_ready=1 in cycle 5. Repeat with DIV, expecting ALUCode=0001.
- READ with mem_ready raised in the 3rd MEM cycle -> MemEn=1, MemtoReg=1, FonteEscrita=1 for 3 cycles, RegEsc=1 in the 3rd only, then IDLE. WRITE with mem_ready held high -> a single MEM cycle with MemOp=1.
- CLEAR with CLEAR_DEPTH=16 -> Clear=1 for 16 cycles, clear_addr 0..15, then IDLE. Assert rst at clear_addr=7 -> next sample shows IDLE, clear_addr=0, instr_ready=1.
- WRITE with mem_ready stuck at 0 and MEM_TIMEOUT=8 -> 8 MEM cycles, then Stop=1, err=1, instr_ready=0. Later instr_valid pulses are ignored; rst clears both flags.
- HALT accepted while instr_valid stays high with ADD -> Stop=1 from the next cycle, no RegEsc ever. Stop stays set over 20 cycles.
